// File: rtl/clk_divider_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : clk_divider_multi                                          |
// | Description : Multi-channel runtime-programmable clock divider. Each     |
// |               channel produces a 50%-duty divided clock (extra cycle of  |
// |               an odd ratio goes to the high phase) and a one-cycle tick  |
// |               on the last cycle of every period. Ratio updates are       |
// |               deferred to the period boundary so outputs never glitch.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk      in   1               system clock, rising edge               |
// |   rst_n    in   1               synchronous active-low reset            |
// |   en       in   CHANNELS        per-channel enable                       |
// |   sync     in   1               restart all channels at count 0         |
// |   ratio    in   CHANNELS*WIDTH  per-channel divisor (0/1 act as 2)      |
// |   div_clk  out  CHANNELS        registered divided clock                |
// |   tick     out  CHANNELS        registered end-of-period pulse          |
// |   pending  out  CHANNELS        requested ratio not yet active          |
// +--------------------------------------------------------------------------+
module clk_divider_multi #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en,
    input  logic                      sync,
    input  logic [CHANNELS*WIDTH-1:0] ratio,
    output logic [CHANNELS-1:0]       div_clk,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       pending
);

    localparam logic [WIDTH-1:0] c_min_ratio = WIDTH'(2);
    localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero      = '0;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] w_raw;
            logic [WIDTH-1:0] w_rin;
            logic [WIDTH-1:0] w_last;
            logic [WIDTH-1:0] w_cnt_nxt;
            logic [WIDTH-1:0] w_act_nxt;
            logic             w_div_nxt;
            logic             w_tick_nxt;
            logic             w_pend_nxt;

            logic [WIDTH-1:0] r_cnt;
            logic [WIDTH-1:0] r_act;
            logic             r_div;
            logic             r_tick;
            logic             r_pend;

            assign w_raw = ratio[gi*WIDTH +: WIDTH];

            // Divisors below 2 cannot produce a valid two-phase clock, so they
            // are treated as 2; this also keeps act-1 from underflowing.
            assign w_rin  = (w_raw < c_min_ratio) ? c_min_ratio : w_raw;
            assign w_last = r_act - c_one;

            // Next count/divisor. A new divisor is only adopted when the
            // period wraps or on sync, which is what makes changes glitch-free.
            always_comb begin
                w_cnt_nxt = r_cnt;
                w_act_nxt = r_act;
                if (sync) begin
                    w_cnt_nxt = c_zero;
                    w_act_nxt = w_rin;
                end else if (en[gi]) begin
                    if (r_cnt == w_last) begin
                        w_cnt_nxt = c_zero;
                        w_act_nxt = w_rin;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end
            end

            // Outputs are derived from the next state so that the registered
            // value always matches the count held in the same cycle.
            // Low phase covers counts below floor(act/2), so odd divisors give
            // the extra cycle to the high phase.
            assign w_div_nxt  = (w_cnt_nxt >= (w_act_nxt >> 1));
            assign w_tick_nxt = en[gi] & (w_cnt_nxt == (w_act_nxt - c_one));
            assign w_pend_nxt = (w_rin != w_act_nxt);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt  <= c_zero;
                    r_act  <= w_rin;
                    r_div  <= 1'b0;
                    r_tick <= 1'b0;
                    r_pend <= 1'b0;
                end else begin
                    r_cnt  <= w_cnt_nxt;
                    r_act  <= w_act_nxt;
                    r_div  <= w_div_nxt;
                    r_tick <= w_tick_nxt;
                    r_pend <= w_pend_nxt;
                end
            end

            assign div_clk[gi] = r_div;
            assign tick[gi]    = r_tick;
            assign pending[gi] = r_pend;
        end
    endgenerate

endmodule
`default_nettype wire
